// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - hazard-to-pipeline-register stall/flush controller with watchdog
module pipeline_stall_ctrl #(
  parameter int CNT_W     = 32,
  parameter int MAX_STALL = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             branch_has_hazard,
  input  logic             err_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       state
);

  localparam int SR_W = $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_STALL      = 2'd1,
    S_FLUSH_PEND = 2'd2,
    S_HALT       = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [SR_W-1:0]  stall_run_q, stall_run_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cycles_q, flush_count_q;
  logic             stall_inc, flush_inc;
  logic             pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c;
  logic [SR_W-1:0]  stall_run_inc;

  assign stall_run_inc = stall_run_q + SR_W'(1);

  // Next-state and pipeline-control decode; FLUSH_PEND is the state that remembers a flush
  always_comb begin
    state_d       = state_q;
    stall_run_d   = stall_run_q;
    timeout_d     = timeout_q;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    pc_write_c    = 1'b1;
    ifid_write_c  = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    if (state_q == S_HALT) begin
      pc_write_c    = 1'b0;
      ifid_write_c  = 1'b0;
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
      if (err_clr) begin
        timeout_d   = 1'b0;
        stall_run_d = '0;
        state_d     = S_RUN;
      end
    end else if (hold) begin
      pc_write_c    = 1'b0;
      ifid_write_c  = 1'b0;
      idex_bubble_c = 1'b1;
      stall_inc     = 1'b1;
      stall_run_d   = stall_run_inc;
      if (branch_has_hazard || state_q == S_FLUSH_PEND) begin
        state_d = S_FLUSH_PEND;
      end else begin
        state_d = S_STALL;
      end
      // Runaway stall: halt and drop any latched flush
      if (stall_run_inc == SR_W'(MAX_STALL)) begin
        timeout_d = 1'b1;
        state_d   = S_HALT;
      end
    end else begin
      stall_run_d = '0;
      state_d     = S_RUN;
      // A flush latched during the stall and a fresh branch collapse into one flush
      if (state_q == S_FLUSH_PEND || branch_has_hazard) begin
        ifid_flush_c = 1'b1;
        flush_inc    = 1'b1;
      end
    end
  end

  // State, watchdog and saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_RUN;
      stall_run_q    <= '0;
      timeout_q      <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      stall_run_q <= stall_run_d;
      timeout_q   <= timeout_d;
      if (stall_inc && stall_cycles_q != {CNT_W{1'b1}}) begin
        stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      end
      if (flush_inc && flush_count_q != {CNT_W{1'b1}}) begin
        flush_count_q <= flush_count_q + CNT_W'(1);
      end
    end
  end

  // While reset is held the pipeline is frozen and filled with NOPs
  always_comb begin
    pc_write    = pc_write_c;
    ifid_write  = ifid_write_c;
    ifid_flush  = ifid_flush_c;
    idex_bubble = idex_bubble_c;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  assign stall_timeout = timeout_q;
  assign stall_cycles  = stall_cycles_q;
  assign flush_count   = flush_count_q;
  assign state         = state_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - directed bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

  localparam int CW = 4;
  localparam int MS = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hold = 1'b0;
  logic          branch_has_hazard = 1'b0;
  logic          err_clr = 1'b0;
  logic          pc_write, ifid_write, ifid_flush, idex_bubble, stall_timeout;
  logic [CW-1:0] stall_cycles, flush_count;
  logic [1:0]    state;
  logic [3:0]    ctl;

  int checks = 0;
  int failures = 0;

  // {pc_write, ifid_write, ifid_flush, idex_bubble}
  localparam logic [3:0] C_RUN   = 4'b1100;
  localparam logic [3:0] C_STALL = 4'b0001;
  localparam logic [3:0] C_FLUSH = 4'b1110;
  localparam logic [3:0] C_HALT  = 4'b0011;

  pipeline_stall_ctrl #(.CNT_W(CW), .MAX_STALL(MS)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .branch_has_hazard(branch_has_hazard),
    .err_clr(err_clr), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .stall_timeout(stall_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .state(state)
  );

  assign ctl = {pc_write, ifid_write, ifid_flush, idex_bubble};

  always #5 clk = ~clk;

  task automatic drive(input logic h, input logic b, input logic e);
    hold = h; branch_has_hazard = b; err_clr = e;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive(1, 1, 0);
    rst_n = 1'b0;
    #1;
    checks++; if (ctl !== C_HALT) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_HALT); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (stall_cycles !== 4'd0 || flush_count !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cycles, flush_count); end
    checks++; if (stall_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", stall_timeout); end
    @(negedge clk);
    drive(0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0);
      checks++; if (ctl !== C_RUN) begin failures++; $display("FAIL idle_ctl cyc=%0d got=%b exp=%b", i, ctl, C_RUN); end
      tick();
    end
    checks++; if (stall_cycles !== 4'd0 || flush_count !== 4'd0 || state !== 2'd0) begin failures++; $display("FAIL idle_end got=%0d/%0d/st%0d exp=0/0/st0", stall_cycles, flush_count, state); end
  endtask

  task automatic test_load_use();
    drive(1, 0, 0);
    checks++; if (ctl !== C_STALL) begin failures++; $display("FAIL lu_ctl got=%b exp=%b", ctl, C_STALL); end
    tick();
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL lu_state_stall got=%0d exp=1", state); end
    drive(0, 0, 0);
    checks++; if (ctl !== C_RUN) begin failures++; $display("FAIL lu_release_ctl got=%b exp=%b", ctl, C_RUN); end
    tick();
    checks++; if (state !== 2'd0 || stall_cycles !== 4'd1) begin failures++; $display("FAIL lu_end got=st%0d/%0d exp=st0/1", state, stall_cycles); end
  endtask

  task automatic test_branch();
    drive(0, 1, 0);
    checks++; if (ctl !== C_FLUSH) begin failures++; $display("FAIL br_ctl got=%b exp=%b", ctl, C_FLUSH); end
    tick();
    checks++; if (flush_count !== 4'd1 || state !== 2'd0 || stall_cycles !== 4'd1) begin failures++; $display("FAIL br_end got=f%0d/st%0d/s%0d exp=f1/st0/s1", flush_count, state, stall_cycles); end
  endtask

  task automatic test_overlap();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0);
      checks++; if (ctl !== C_STALL) begin failures++; $display("FAIL ov_stall_ctl cyc=%0d got=%b exp=%b", i, ctl, C_STALL); end
      tick();
      checks++; if (state !== 2'd2) begin failures++; $display("FAIL ov_state cyc=%0d got=%0d exp=2", i, state); end
    end
    drive(0, 0, 0);
    checks++; if (ctl !== C_FLUSH) begin failures++; $display("FAIL ov_apply_ctl got=%b exp=%b", ctl, C_FLUSH); end
    tick();
    checks++; if (flush_count !== 4'd1 || stall_cycles !== 4'd2 || state !== 2'd0) begin failures++; $display("FAIL ov_end got=f%0d/s%0d/st%0d exp=f1/s2/st0", flush_count, stall_cycles, state); end
    drive(0, 0, 0);
    checks++; if (ctl !== C_RUN) begin failures++; $display("FAIL ov_once_ctl got=%b exp=%b", ctl, C_RUN); end
    tick();
    // STALL picks up a later branch and moves to FLUSH_PEND; a branch on release is merged
    drive(1, 0, 0); tick();
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL ov_s_state got=%0d exp=1", state); end
    drive(1, 1, 0); tick();
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL ov_s2fp_state got=%0d exp=2", state); end
    drive(0, 1, 0);
    checks++; if (ctl !== C_FLUSH) begin failures++; $display("FAIL ov_merge_ctl got=%b exp=%b", ctl, C_FLUSH); end
    tick();
    checks++; if (flush_count !== 4'd2 || stall_cycles !== 4'd4) begin failures++; $display("FAIL ov_merge_cnt got=f%0d/s%0d exp=f2/s4", flush_count, stall_cycles); end
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 0; i < MS; i++) begin
      drive(1, (i == 0), 0);
      checks++; if (ctl !== C_STALL) begin failures++; $display("FAIL wd_stall_ctl cyc=%0d got=%b exp=%b", i, ctl, C_STALL); end
      tick();
      if (i == MS - 2) begin
        checks++; if (state !== 2'd2 || stall_timeout !== 1'b0) begin failures++; $display("FAIL wd_pre_trip got=st%0d/t%b exp=st2/t0", state, stall_timeout); end
      end
    end
    checks++; if (state !== 2'd3 || stall_timeout !== 1'b1) begin failures++; $display("FAIL wd_trip got=st%0d/t%b exp=st3/t1", state, stall_timeout); end
    checks++; if (stall_cycles !== 4'd15) begin failures++; $display("FAIL wd_sat got=%0d exp=15", stall_cycles); end
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0);
      checks++; if (ctl !== C_HALT) begin failures++; $display("FAIL wd_halt_ctl cyc=%0d got=%b exp=%b", i, ctl, C_HALT); end
      tick();
    end
    checks++; if (state !== 2'd3 || flush_count !== 4'd0) begin failures++; $display("FAIL wd_halt_hold got=st%0d/f%0d exp=st3/f0", state, flush_count); end
    drive(0, 0, 1);
    checks++; if (ctl !== C_HALT) begin failures++; $display("FAIL wd_clr_ctl got=%b exp=%b", ctl, C_HALT); end
    tick();
    checks++; if (state !== 2'd0 || stall_timeout !== 1'b0) begin failures++; $display("FAIL wd_clr got=st%0d/t%b exp=st0/t0", state, stall_timeout); end
    drive(0, 0, 0);
    checks++; if (ctl !== C_RUN) begin failures++; $display("FAIL wd_no_flush got=%b exp=%b", ctl, C_RUN); end
    tick();
    // err_clr outside HALT does nothing; the run counter restarted, so MS-1 holds do not trip
    for (int i = 0; i < MS - 1; i++) begin
      drive(1, 0, (i == 3));
      tick();
    end
    checks++; if (state !== 2'd1 || stall_timeout !== 1'b0 || stall_cycles !== 4'd15) begin failures++; $display("FAIL wd_no_trip got=st%0d/t%b/s%0d exp=st1/t0/s15", state, stall_timeout, stall_cycles); end
    drive(0, 0, 0); tick();
    drive(1, 0, 0); tick();
    checks++; if (state !== 2'd1 || stall_timeout !== 1'b0) begin failures++; $display("FAIL wd_run_cleared got=st%0d/t%b exp=st1/t0", state, stall_timeout); end
    drive(0, 0, 0); tick();
  endtask

  task automatic test_reset_midstall();
    do_reset();
    drive(1, 1, 0); tick();
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL rm_pend got=%0d exp=2", state); end
    rst_n = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || ctl !== C_HALT || stall_cycles !== 4'd0) begin failures++; $display("FAIL rm_async got=st%0d/c%b/s%0d exp=st0/c0011/s0", state, ctl, stall_cycles); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0);
    checks++; if (ctl !== C_RUN) begin failures++; $display("FAIL rm_no_flush got=%b exp=%b", ctl, C_RUN); end
    tick();
    checks++; if (flush_count !== 4'd0) begin failures++; $display("FAIL rm_fcnt got=%0d exp=0", flush_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(0, 1, 0);
      tick();
    end
    checks++; if (flush_count !== 4'd15) begin failures++; $display("FAIL b2b_fsat got=%0d exp=15", flush_count); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load_use();
    test_branch();
    test_overlap();
    test_watchdog();
    test_reset_midstall();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
